// File: rtl/channel_merge_rr.sv
// K-input round-robin merge into a single registered output slot.
// Each input may hold priority for up to BURST consecutive grants before it rotates.
module channel_merge_rr #(
    parameter int K     = 4,
    parameter int N     = 8,
    parameter int BURST = 1,
    parameter int TAG   = 0,
    localparam int PW   = $clog2(K),
    localparam int W    = N + ((TAG != 0) ? PW : 0)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [K-1:0]   in_v,
    input  logic [K*N-1:0] in_d,
    output logic [K-1:0]   in_a,
    output logic           out_v,
    output logic [W-1:0]   out_d,
    input  logic           out_a
);

    logic [PW-1:0] ptr_reg, ptr_next;
    logic [7:0]    bcnt_reg, bcnt_next;
    logic          out_v_reg, out_v_next;
    logic [W-1:0]  out_d_reg, out_d_next;

    logic [K-1:0]  hi_mask;
    logic [K-1:0]  hi_req;
    logic [PW-1:0] win;
    logic [PW-1:0] win_inc;
    logic [N-1:0]  win_d;
    logic [W-1:0]  load_d;
    logic          slot_free;
    logic          grant;

    // Requests at or above the pointer take precedence; the rest cover the wrap.
    for (genvar gi = 0; gi < K; gi++) begin : g_mask
        assign hi_mask[gi] = (PW'(gi) >= ptr_reg);
        assign in_a[gi]    = grant && (win == PW'(gi));
    end

    assign hi_req = in_v & hi_mask;

    always_comb begin
        win = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (in_v[i]) win = PW'(i);
        end
        for (int i = K - 1; i >= 0; i--) begin
            if (hi_req[i]) win = PW'(i);
        end
    end

    assign win_inc   = (win == PW'(K - 1)) ? '0 : win + 1'b1;
    assign win_d     = in_d[win*N +: N];
    assign slot_free = ~out_v_reg | out_a;
    assign grant     = slot_free && (|in_v) && !reset;

    if (TAG != 0) begin : g_tag
        assign load_d = {win, win_d};
    end else begin : g_notag
        assign load_d = win_d;
    end

    always_comb begin
        ptr_next   = ptr_reg;
        bcnt_next  = bcnt_reg;
        out_v_next = out_v_reg;
        out_d_next = out_d_reg;
        if (grant) begin
            out_v_next = 1'b1;
            out_d_next = load_d;
            if (win == ptr_reg) begin
                if ({1'b0, bcnt_reg} + 9'd1 < 9'(BURST)) begin
                    bcnt_next = bcnt_reg + 8'd1;
                end else begin
                    ptr_next  = win_inc;
                    bcnt_next = '0;
                end
            end else if (BURST > 1) begin
                // The jump itself counts as the first grant of the new burst.
                ptr_next  = win;
                bcnt_next = 8'd1;
            end else begin
                ptr_next  = win_inc;
                bcnt_next = '0;
            end
        end else if (out_a) begin
            out_v_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg   <= '0;
            bcnt_reg  <= '0;
            out_v_reg <= 1'b0;
            out_d_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            bcnt_reg  <= bcnt_next;
            out_v_reg <= out_v_next;
            out_d_reg <= out_d_next;
        end
    end

    assign out_v = out_v_reg;
    assign out_d = out_d_reg;

endmodule

// File: tb/tb_channel_merge_rr.sv
// Directed bench for channel_merge_rr: round-robin, burst, tag, backpressure,
// reset behaviour, plus a random run with an output scoreboard.
module tb_channel_merge_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   total = 0;
    int   bad   = 0;

    // K=4, N=8, BURST=1, TAG=0
    logic [3:0]  v0;
    logic [31:0] d0;
    logic [3:0]  a0;
    logic        ov0;
    logic [7:0]  od0;
    logic        oa0;
    // K=4, N=8, BURST=3, TAG=0
    logic [3:0]  v1;
    logic [31:0] d1;
    logic [3:0]  a1;
    logic        ov1;
    logic [7:0]  od1;
    logic        oa1;
    // K=3, N=8, BURST=1, TAG=1
    logic [2:0]  v2;
    logic [23:0] d2;
    logic [2:0]  a2;
    logic        ov2;
    logic [9:0]  od2;
    logic        oa2;

    channel_merge_rr #(.K(4), .N(8), .BURST(1), .TAG(0)) dut (
        .clk(clk), .reset(reset), .in_v(v0), .in_d(d0), .in_a(a0),
        .out_v(ov0), .out_d(od0), .out_a(oa0));

    channel_merge_rr #(.K(4), .N(8), .BURST(3), .TAG(0)) dut_b (
        .clk(clk), .reset(reset), .in_v(v1), .in_d(d1), .in_a(a1),
        .out_v(ov1), .out_d(od1), .out_a(oa1));

    channel_merge_rr #(.K(3), .N(8), .BURST(1), .TAG(1)) dut_t (
        .clk(clk), .reset(reset), .in_v(v2), .in_d(d2), .in_a(a2),
        .out_v(ov2), .out_d(od2), .out_a(oa2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v0 = '0; v1 = '0; v2 = '0;
        d0 = '0; d1 = '0; d2 = '0;
        oa0 = 1'b0; oa1 = 1'b0; oa2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        v0 = 4'hf; v1 = 4'hf; v2 = 3'h7;
        oa0 = 1'b1; oa1 = 1'b1; oa2 = 1'b1;
        tick();
        total++;
        if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_v got %b want 0", ov0); end
        total++;
        if (od0 !== 8'h00) begin bad++; $display("FAIL reset_out_d got %h want 00", od0); end
        total++;
        if (a0 !== 4'b0000) begin bad++; $display("FAIL reset_in_a got %b want 0000", a0); end
        total++;
        if (a1 !== 4'b0000) begin bad++; $display("FAIL reset_in_a_b got %b want 0000", a1); end
        total++;
        if ({ov2, od2} !== 11'd0) begin bad++; $display("FAIL reset_tag_out got %b/%h want 0/000", ov2, od2); end
        $display("test_reset done");
    endtask

    task automatic test_rr();
        logic [3:0] exp_a;
        logic [7:0] exp_d;
        do_reset();
        d0 = {8'h43, 8'h42, 8'h41, 8'h40};
        v0 = 4'hf;
        oa0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_a = 4'(1 << (i % 4));
            exp_d = 8'h40 + 8'(i % 4);
            total++;
            if (a0 !== exp_a) begin bad++; $display("FAIL rr_in_a cycle %0d got %b want %b", i, a0, exp_a); end
            tick();
            total++;
            if (ov0 !== 1'b1 || od0 !== exp_d) begin
                bad++; $display("FAIL rr_out cycle %0d got %b/%h want 1/%h", i, ov0, od0, exp_d);
            end
            $display("rr cycle %0d grant %b out %h", i, a0, od0);
        end
        v0 = '0;
    endtask

    task automatic test_burst();
        int         ord[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic [3:0] exp_a;
        logic [7:0] exp_d;
        do_reset();
        d1 = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        v1 = 4'b0011;
        oa1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            exp_a = 4'(1 << ord[i]);
            exp_d = 8'hD0 + 8'(ord[i]);
            total++;
            if (a1 !== exp_a) begin bad++; $display("FAIL burst_in_a cycle %0d got %b want %b", i, a1, exp_a); end
            tick();
            total++;
            if (ov1 !== 1'b1 || od1 !== exp_d) begin
                bad++; $display("FAIL burst_out cycle %0d got %b/%h want 1/%h", i, ov1, od1, exp_d);
            end
            $display("burst cycle %0d grant %b out %h", i, a1, od1);
        end
        v1 = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        v0 = 4'b0100;
        d0 = 32'h00A5_0000;
        oa0 = 1'b0;
        #1;
        total++;
        if (a0 !== 4'b0100) begin bad++; $display("FAIL bp_first_grant got %b want 0100", a0); end
        tick();
        total++;
        if (ov0 !== 1'b1 || od0 !== 8'hA5) begin bad++; $display("FAIL bp_load got %b/%h want 1/a5", ov0, od0); end
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (a0 !== 4'b0000) begin bad++; $display("FAIL bp_stall_in_a cycle %0d got %b want 0000", i, a0); end
            total++;
            if (ov0 !== 1'b1 || od0 !== 8'hA5) begin
                bad++; $display("FAIL bp_hold cycle %0d got %b/%h want 1/a5", i, ov0, od0);
            end
            $display("bp stall %0d out_v %b out_d %h", i, ov0, od0);
            tick();
        end
        oa0 = 1'b1;
        d0 = 32'h005A_0000;
        #1;
        total++;
        if (a0 !== 4'b0100) begin bad++; $display("FAIL bp_release_grant got %b want 0100", a0); end
        tick();
        total++;
        if (ov0 !== 1'b1 || od0 !== 8'h5A) begin bad++; $display("FAIL bp_next_item got %b/%h want 1/5a", ov0, od0); end
        v0 = '0;
        #1;
        total++;
        if (a0 !== 4'b0000) begin bad++; $display("FAIL bp_idle_in_a got %b want 0000", a0); end
        tick();
        total++;
        if (ov0 !== 1'b0 || od0 !== 8'h5A) begin bad++; $display("FAIL bp_drain got %b/%h want 0/5a", ov0, od0); end
        $display("bp drained out_v %b out_d %h", ov0, od0);
    endtask

    task automatic test_tag();
        logic [2:0] vin[4]  = '{3'b100, 3'b111, 3'b110, 3'b011};
        logic [2:0] ea[4]   = '{3'b100, 3'b001, 3'b010, 3'b001};
        logic [9:0] ed[4]   = '{10'b10_0011_1100, {2'b00, 8'h11}, {2'b01, 8'h22}, {2'b00, 8'h11}};
        do_reset();
        d2 = {8'h3C, 8'h22, 8'h11};
        oa2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v2 = vin[i];
            #1;
            total++;
            if (a2 !== ea[i]) begin bad++; $display("FAIL tag_in_a step %0d got %b want %b", i, a2, ea[i]); end
            tick();
            total++;
            if (ov2 !== 1'b1 || od2 !== ed[i]) begin
                bad++; $display("FAIL tag_out step %0d got %b/%b want 1/%b", i, ov2, od2, ed[i]);
            end
            $display("tag step %0d grant %b out %b", i, a2, od2);
        end
        v2 = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d0 = {8'h43, 8'h42, 8'h41, 8'h40};
        v0 = 4'hf;
        oa0 = 1'b0;
        tick();
        #1;
        total++;
        if (ov0 !== 1'b1) begin bad++; $display("FAIL midrst_pre got %b want 1", ov0); end
        reset = 1'b1;
        #1;
        total++;
        if (ov0 !== 1'b0 || od0 !== 8'h00) begin bad++; $display("FAIL midrst_clear got %b/%h want 0/00", ov0, od0); end
        total++;
        if (a0 !== 4'b0000) begin bad++; $display("FAIL midrst_in_a got %b want 0000", a0); end
        tick();
        total++;
        if (a0 !== 4'b0000 || ov0 !== 1'b0) begin bad++; $display("FAIL midrst_held got %b/%b want 0000/0", a0, ov0); end
        reset = 1'b0;
        oa0 = 1'b1;
        #1;
        total++;
        if (a0 !== 4'b0001) begin bad++; $display("FAIL midrst_first_grant got %b want 0001", a0); end
        tick();
        total++;
        if (ov0 !== 1'b1 || od0 !== 8'h40) begin bad++; $display("FAIL midrst_out got %b/%h want 1/40", ov0, od0); end
        $display("midrst first out %h", od0);
        v0 = '0;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] exp_d;
        int         waitc[4] = '{0, 0, 0, 0};
        int         bad_before;
        bad_before = bad;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v0  = 4'($urandom);
            d0  = $urandom;
            oa0 = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if ((a0 & ~v0) !== 4'b0000 || (a0 & (a0 - 4'd1)) !== 4'b0000) begin
                bad++; $display("FAIL rand_in_a_legal cycle %0d got %b with in_v %b", c, a0, v0);
            end
            total++;
            if (((~ov0 | oa0) && v0 != 4'b0) !== (a0 != 4'b0)) begin
                bad++; $display("FAIL rand_grant_expected cycle %0d got %b want grant=%b", c, a0,
                                ((~ov0 | oa0) && v0 != 4'b0));
            end
            if (ov0 && oa0) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious_out cycle %0d got %h want none", c, od0);
                end else begin
                    exp_d = q.pop_front();
                    if (od0 !== exp_d) begin bad++; $display("FAIL rand_out_data cycle %0d got %h want %h", c, od0, exp_d); end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (a0[i]) q.push_back(d0[i*8 +: 8]);
                if (!v0[i] || a0[i]) waitc[i] = 0;
                else if (a0 != 4'b0) waitc[i]++;
                total++;
                if (waitc[i] > 3) begin bad++; $display("FAIL rand_wait_bound input %0d got %0d want <=3", i, waitc[i]); end
            end
            tick();
        end
        v0 = '0;
        $display("random run done queue=%0d new_bad=%0d", q.size(), bad - bad_before);
    endtask

    initial begin
        reset = 1'b1;
        v0 = '0; v1 = '0; v2 = '0;
        d0 = '0; d1 = '0; d2 = '0;
        oa0 = 1'b0; oa1 = 1'b0; oa2 = 1'b0;
        test_reset();
        test_rr();
        test_burst();
        test_backpressure();
        test_tag();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
